// File: rtl/lsu_pkg.sv
// lsu_pkg: size encodings and FSM states shared by the load/store unit
package lsu_pkg;
    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;
    typedef enum logic [1:0] {IDLE, LOAD_WAIT, RMW_WRITE} state_e;
endpackage

// File: rtl/lsu_byte_lane.sv
// lsu_byte_lane: lane extraction/extension for loads and lane merge for sub-word stores
module lsu_byte_lane
    import lsu_pkg::*;
(
    input  logic [31:0] word_i,
    input  logic [1:0]  lane_i,
    input  logic [1:0]  size_i,
    input  logic        unsigned_i,
    input  logic [31:0] wdata_i,
    output logic [31:0] load_o,
    output logic [31:0] merged_o
);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] bm, hm;
    always_comb begin
        b = lane_i == 2'd0 ? word_i[7:0] : lane_i == 2'd1 ? word_i[15:8] :
            lane_i == 2'd2 ? word_i[23:16] : word_i[31:24];
        h = lane_i[1] ? word_i[31:16] : word_i[15:0];
        bm = 32'h0000_00FF << {lane_i, 3'b000};
        hm = lane_i[1] ? 32'hFFFF_0000 : 32'h0000_FFFF;
        load_o = size_i == SZ_BYTE ? {{24{~unsigned_i & b[7]}}, b} :
                 size_i == SZ_HALF ? {{16{~unsigned_i & h[15]}}, h} : word_i;
        merged_o = size_i == SZ_BYTE ? (word_i & ~bm) | ({4{wdata_i[7:0]}} & bm) :
                   size_i == SZ_HALF ? (word_i & ~hm) | ({2{wdata_i[15:0]}} & hm) : wdata_i;
    end
endmodule

// File: rtl/load_store_unit.sv
// load_store_unit: MEM-stage adapter to a word-only RAM with sub-word loads and RMW stores
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req_valid,
    input  logic                  req_store,
    input  logic [1:0]            req_size,
    input  logic                  req_unsigned,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    output logic                  stall,
    output logic                  rdata_valid,
    output logic [DATA_WIDTH-1:0] rdata,
    output logic                  misaligned,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_data,
    output logic                  mem_MemWrite,
    output logic                  mem_MemRead,
    input  logic [DATA_WIDTH-1:0] mem_q
);
    state_e                state_q, state_d;
    logic [1:0]            size_q, lane_q;
    logic                  uns_q;
    logic [DATA_WIDTH-1:0] wdata_q;
    logic [ADDR_WIDTH-1:0] waddr_q;
    logic                  idle, bad, accept, word_st, multi;
    logic [31:0]           lane_load, lane_merged;

    lsu_byte_lane u_lane (
        .word_i     (mem_q),
        .lane_i     (lane_q),
        .size_i     (size_q),
        .unsigned_i (uns_q),
        .wdata_i    (wdata_q),
        .load_o     (lane_load),
        .merged_o   (lane_merged)
    );

    always_comb begin
        idle    = state_q == IDLE;
        bad     = req_size == 2'b11 || (req_size == SZ_HALF && req_addr[0]) ||
                  (req_size == SZ_WORD && req_addr[1:0] != 2'b00);
        accept  = idle && req_valid && !bad;
        word_st = accept && req_store && req_size == SZ_WORD;
        multi   = accept && !word_st;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            size_q  <= '0;
            lane_q  <= '0;
            uns_q   <= 1'b0;
            wdata_q <= '0;
            waddr_q <= '0;
        end else begin
            state_q <= state_d;
            if (idle) begin
                size_q  <= req_size;
                lane_q  <= req_addr[1:0];
                uns_q   <= req_unsigned;
                wdata_q <= req_wdata;
                waddr_q <= {req_addr[ADDR_WIDTH-1:2], 2'b00};
            end
        end
    end

    always_comb begin
        state_d = IDLE;
        if (multi) state_d = req_store ? RMW_WRITE : LOAD_WAIT;
    end

    // Everything except the address is squashed while reset is held so an abandoned RMW never writes
    always_comb begin
        mem_addr     = idle ? {req_addr[ADDR_WIDTH-1:2], 2'b00} : waddr_q;
        stall        = rst_n && multi;
        mem_MemRead  = rst_n && multi;
        mem_MemWrite = rst_n && (word_st || state_q == RMW_WRITE);
        misaligned   = rst_n && idle && req_valid && bad;
        rdata_valid  = rst_n && state_q == LOAD_WAIT;
        rdata        = rdata_valid ? lane_load : '0;
        mem_data     = !rst_n ? '0 : state_q == RMW_WRITE ? lane_merged : word_st ? req_wdata : '0;
    end
endmodule

// File: tb/tb_load_store_unit.sv
// tb_load_store_unit: directed checks of the load/store unit against a behavioural word RAM
module tb_load_store_unit;
    logic        clk = 1'b0;
    logic        rst_n, req_valid, req_store, req_unsigned;
    logic [1:0]  req_size;
    logic [31:0] req_addr, req_wdata;
    logic        stall, rdata_valid, misaligned, mem_MemWrite, mem_MemRead;
    logic [31:0] rdata, mem_addr, mem_data, mem_q;
    logic [31:0] ram [0:255];
    logic [31:0] ram_addr_q = '0;
    int          errors = 0, checks = 0, stalls;
    logic [31:0] rd;

    always #5 clk = ~clk;

    load_store_unit dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_store(req_store),
        .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
        .req_wdata(req_wdata), .stall(stall), .rdata_valid(rdata_valid), .rdata(rdata),
        .misaligned(misaligned), .mem_addr(mem_addr), .mem_data(mem_data),
        .mem_MemWrite(mem_MemWrite), .mem_MemRead(mem_MemRead), .mem_q(mem_q)
    );

    always @(posedge clk) begin
        if (mem_MemWrite && !mem_MemRead) ram[mem_addr[9:2]] <= mem_data;
        ram_addr_q <= mem_addr;
    end
    assign mem_q = ram[ram_addr_q[9:2]];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic st, input logic [1:0] sz, input logic un,
                         input logic [31:0] a, input logic [31:0] wd);
        req_valid = 1'b1; req_store = st; req_size = sz; req_unsigned = un;
        req_addr = a; req_wdata = wd;
    endtask

    task automatic op(input logic st, input logic [1:0] sz, input logic un,
                      input logic [31:0] a, input logic [31:0] wd,
                      output int ns, output logic [31:0] r);
        @(negedge clk);
        drive(st, sz, un, a, wd);
        ns = 0;
        r = '0;
        for (int i = 0; i < 4; i++) begin
            #1;
            if (rdata_valid) r = rdata;
            if (!stall) break;
            ns++;
            @(negedge clk);
        end
        @(posedge clk);
        #1 req_valid = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0;
        drive(1'b1, 2'b10, 1'b0, 32'h10, 32'hFFFF_FFFF);
        @(negedge clk); #1;
        chk("reset_ctl", {31'd0, stall, mem_MemWrite, mem_MemRead, rdata_valid, misaligned}, 32'd0);
        chk("reset_rdata", rdata, 32'd0);
        chk("reset_mem_data", mem_data, 32'd0);
        @(posedge clk); #1 rst_n = 1'b1; req_valid = 1'b0;

        op(1'b1, 2'b10, 1'b0, 32'h10, 32'hDEAD_BEEF, stalls, rd);
        chk("sw_stalls", stalls, 0);
        chk("sw_ram", ram[4], 32'hDEAD_BEEF);
        op(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, stalls, rd);
        chk("lw_stalls", stalls, 1);
        chk("lw_rdata", rd, 32'hDEAD_BEEF);

        op(1'b1, 2'b10, 1'b0, 32'h20, 32'h80FF_7F01, stalls, rd);
        op(1'b0, 2'b00, 1'b0, 32'h22, 32'h0, stalls, rd);
        chk("lb_22", rd, 32'hFFFF_FFFF);
        op(1'b0, 2'b00, 1'b1, 32'h23, 32'h0, stalls, rd);
        chk("lbu_23", rd, 32'h0000_0080);
        op(1'b0, 2'b00, 1'b0, 32'h20, 32'h0, stalls, rd);
        chk("lb_20", rd, 32'h0000_0001);
        op(1'b0, 2'b01, 1'b0, 32'h22, 32'h0, stalls, rd);
        chk("lh_22", rd, 32'hFFFF_80FF);
        op(1'b0, 2'b01, 1'b1, 32'h20, 32'h0, stalls, rd);
        chk("lhu_20", rd, 32'h0000_7F01);
        op(1'b1, 2'b01, 1'b0, 32'h22, 32'hABCD_1234, stalls, rd);
        chk("sh_stalls", stalls, 1);
        chk("sh_ram", ram[8], 32'h1234_7F01);

        op(1'b1, 2'b10, 1'b0, 32'h30, 32'h1122_3344, stalls, rd);
        @(negedge clk);
        drive(1'b1, 2'b00, 1'b0, 32'h31, 32'h0000_00AA);
        #1;
        chk("sb_c1_ctl", {29'd0, stall, mem_MemRead, mem_MemWrite}, 32'b110);
        chk("sb_c1_addr", mem_addr, 32'h30);
        @(negedge clk); #1;
        chk("sb_c2_ctl", {29'd0, stall, mem_MemRead, mem_MemWrite}, 32'b001);
        chk("sb_c2_data", mem_data, 32'h1122_AA44);
        @(posedge clk); #1 req_valid = 1'b0;
        chk("sb_ram", ram[12], 32'h1122_AA44);

        @(negedge clk);
        drive(1'b0, 2'b10, 1'b0, 32'h12, 32'h0); #1;
        chk("mis_lw", {28'd0, misaligned, stall, mem_MemRead, mem_MemWrite}, 32'b1000);
        @(negedge clk);
        drive(1'b1, 2'b01, 1'b0, 32'h31, 32'h0000_5555); #1;
        chk("mis_sh", {28'd0, misaligned, stall, mem_MemRead, mem_MemWrite}, 32'b1000);
        @(negedge clk);
        drive(1'b1, 2'b11, 1'b0, 32'h10, 32'h0); #1;
        chk("mis_sz11", {28'd0, misaligned, stall, mem_MemRead, mem_MemWrite}, 32'b1000);
        @(negedge clk);
        req_valid = 1'b0; #1;
        chk("mis_idle", {30'd0, rdata_valid, misaligned}, 32'd0);
        chk("mis_ram10", ram[4], 32'hDEAD_BEEF);
        chk("mis_ram30", ram[12], 32'h1122_AA44);

        op(1'b1, 2'b10, 1'b0, 32'h40, 32'h0, stalls, rd);
        @(negedge clk);
        drive(1'b1, 2'b00, 1'b0, 32'h40, 32'h0000_0055); #1;
        chk("rst_rmw_c1", {31'd0, stall}, 32'd1);
        @(negedge clk);
        rst_n = 1'b0; #1;
        chk("rst_rmw_ctl", {27'd0, stall, mem_MemWrite, mem_MemRead, rdata_valid, misaligned}, 32'd0);
        chk("rst_rmw_data", mem_data | rdata, 32'd0);
        @(posedge clk); #1 rst_n = 1'b1; req_valid = 1'b0;
        chk("rst_rmw_ram", ram[16], 32'd0);
        @(negedge clk); #1;
        chk("rst_idle", {30'd0, mem_MemWrite, rdata_valid}, 32'd0);
        op(1'b0, 2'b00, 1'b1, 32'h40, 32'h0, stalls, rd);
        chk("rst_after_lbu_stalls", stalls, 1);
        chk("rst_after_lbu", rd, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
